// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns the SPI slave byte stream into register-bus cycles.
//   clk_i/rst_i            system clock, synchronous active-high reset
//   spi_cs_i               raw chip-select (active-low, asynchronous)
//   spi_new_octet_i        byte strobe from the SPI slave (falling edge = byte done)
//   spi_rx_i / spi_tx_o    received byte / byte to shift out next
//   reg_*                  register bus: req held until ack or timeout
//   bus_err_o              sticky error (timeout, write overrun, read underrun)
//   busy_o                 frame active or bus cycle pending
module spi_reg_ctrl #(
  parameter logic [6:0]  DEV_ID  = 7'h5A,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_cs_i,
  input  logic       spi_new_octet_i,
  input  logic [7:0] spi_rx_i,
  output logic [7:0] spi_tx_o,
  output logic [6:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_req_o,
  input  logic [7:0] reg_rdata_i,
  input  logic       reg_ack_i,
  output logic       bus_err_o,
  output logic       busy_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CMD, WR, RD_TA, RD} fstate_e;
  typedef enum logic       {B_IDLE, B_WAIT}          bstate_e;

  fstate_e    fstate_q;
  bstate_e    bstate_q;

  logic       oct_s1_q, oct_s2_q, oct_prev_q;
  logic       cs_s1_q, cs_s2_q, cs_s3_q;

  logic [7:0] tx_q;
  logic [6:0] addr_q;
  logic [7:0] wdata_q;
  logic       we_q;
  logic       req_q;
  logic       err_q;
  logic [7:0] tcnt_q;
  logic [7:0] hold_q;
  logic       pf_valid_q;

  logic       byte_ev;
  logic       frame_ev;
  logic       bus_idle;
  logic       bus_tmo;
  logic       launch;
  logic       launch_we;
  logic       err_set;
  logic       err_clr;
  logic       addr_load;

  always_comb begin
    byte_ev   = oct_prev_q & ~oct_s2_q;
    // CS takes one more flop than the strobe, so a byte finishing at CS rise
    // is seen here before the frame is torn down.
    frame_ev  = byte_ev & ~cs_s3_q;
    bus_idle  = (bstate_q == B_IDLE);
    bus_tmo   = (bstate_q == B_WAIT) && !reg_ack_i && (tcnt_q == TMO_LAST);
    launch    = 1'b0;
    launch_we = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    addr_load = 1'b0;
    if (frame_ev) begin
      case (fstate_q)
        CMD: begin
          err_clr   = 1'b1;
          addr_load = 1'b1;
          if (spi_rx_i[7]) begin
            launch  = bus_idle;
            err_set = !bus_idle;
          end
        end
        WR: begin
          launch    = bus_idle;
          launch_we = bus_idle;
          err_set   = !bus_idle;
        end
        RD_TA, RD: begin
          launch    = bus_idle;
          err_set   = !pf_valid_q;
          addr_load = pf_valid_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fstate_q   <= IDLE;
      bstate_q   <= B_IDLE;
      oct_s1_q   <= 1'b0;
      oct_s2_q   <= 1'b0;
      oct_prev_q <= 1'b0;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_s3_q    <= 1'b1;
      tx_q       <= {1'b0, DEV_ID};
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= '0;
      hold_q     <= '0;
      pf_valid_q <= 1'b0;
    end else begin
      oct_s1_q   <= spi_new_octet_i;
      oct_s2_q   <= oct_s1_q;
      oct_prev_q <= oct_s2_q;
      cs_s1_q    <= spi_cs_i;
      cs_s2_q    <= cs_s1_q;
      cs_s3_q    <= cs_s2_q;

      if (err_set || bus_tmo) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end

      // Frame FSM
      if (fstate_q != IDLE && cs_s3_q) begin
        fstate_q   <= IDLE;
        pf_valid_q <= 1'b0;
      end else begin
        case (fstate_q)
          IDLE: begin
            tx_q       <= {err_q, DEV_ID};
            pf_valid_q <= 1'b0;
            if (!cs_s3_q) begin
              fstate_q <= CMD;
            end
          end
          CMD: begin
            if (byte_ev) begin
              addr_q <= spi_rx_i[6:0];
              if (spi_rx_i[7]) begin
                fstate_q   <= RD_TA;
                tx_q       <= 8'hFF;
                pf_valid_q <= 1'b0;
              end else begin
                fstate_q <= WR;
              end
            end
          end
          WR: begin
            if (byte_ev && bus_idle) begin
              wdata_q <= spi_rx_i;
            end
          end
          RD_TA, RD: begin
            if (byte_ev) begin
              fstate_q   <= RD;
              pf_valid_q <= 1'b0;
              if (pf_valid_q) begin
                tx_q   <= hold_q;
                addr_q <= addr_q + 7'd1;
              end else begin
                tx_q <= 8'hFF;
              end
            end
          end
          default: fstate_q <= IDLE;
        endcase
      end

      // Bus FSM; a completing read sets the prefetch after any frame-side clear
      case (bstate_q)
        B_IDLE: begin
          if (launch) begin
            bstate_q <= B_WAIT;
            req_q    <= 1'b1;
            we_q     <= launch_we;
            tcnt_q   <= '0;
          end
        end
        B_WAIT: begin
          if (reg_ack_i || bus_tmo) begin
            bstate_q <= B_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            if (we_q) begin
              if (!addr_load) begin
                addr_q <= addr_q + 7'd1;
              end
            end else begin
              hold_q     <= reg_ack_i ? reg_rdata_i : 8'hFF;
              pf_valid_q <= 1'b1;
            end
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        default: bstate_q <= B_IDLE;
      endcase
    end
  end

  assign spi_tx_o    = tx_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_req_o   = req_q;
  assign bus_err_o   = err_q;
  assign busy_o      = (fstate_q != IDLE) || (bstate_q == B_WAIT);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       spi_cs_i;
  logic       spi_new_octet_i;
  logic [7:0] spi_rx_i;
  logic [7:0] spi_tx_o;
  logic [6:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_we_o;
  logic       reg_req_o;
  logic [7:0] reg_rdata_i;
  logic       reg_ack_i;
  logic       bus_err_o;
  logic       busy_o;

  spi_reg_ctrl #(.DEV_ID(7'h5A), .TIMEOUT(63)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .spi_cs_i        (spi_cs_i),
    .spi_new_octet_i (spi_new_octet_i),
    .spi_rx_i        (spi_rx_i),
    .spi_tx_o        (spi_tx_o),
    .reg_addr_o      (reg_addr_o),
    .reg_wdata_o     (reg_wdata_o),
    .reg_we_o        (reg_we_o),
    .reg_req_o       (reg_req_o),
    .reg_rdata_i     (reg_rdata_i),
    .reg_ack_i       (reg_ack_i),
    .bus_err_o       (bus_err_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_tx[$];
  logic [14:0] exp_wr[$];
  logic [7:0]  mem[0:127];
  int          ack_delay = 2;
  bit          ack_en = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-bus slave: acks after ack_delay cycles, checks writes against the scoreboard.
  initial begin : responder
    int          wcnt;
    logic [14:0] e;
    wcnt        = 0;
    reg_ack_i   = 1'b0;
    reg_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (reg_ack_i) begin
        reg_ack_i = 1'b0;
        wcnt      = 0;
      end else if (reg_req_o) begin
        wcnt++;
        if (ack_en && wcnt >= ack_delay) begin
          reg_ack_i = 1'b1;
          if (reg_we_o) begin
            if (exp_wr.size() > 0) e = exp_wr.pop_front();
            else                   e = 'x;
            chk("bus_write", {17'd0, reg_addr_o, reg_wdata_o}, {17'd0, e});
            mem[reg_addr_o] = reg_wdata_o;
          end else begin
            reg_rdata_i = mem[reg_addr_o];
          end
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // One SPI byte of len clk cycles; MISO is checked at the start of the byte.
  task automatic send_byte(input logic [7:0] b, input int len);
    logic [7:0] e;
    repeat (8) @(negedge clk);
    if (exp_tx.size() > 0) e = exp_tx.pop_front();
    else                   e = 'x;
    chk("miso", {24'd0, spi_tx_o}, {24'd0, e});
    spi_rx_i = b;
    repeat (len / 2 - 8) @(negedge clk);
    spi_new_octet_i = 1'b1;
    repeat (len / 2) @(negedge clk);
    spi_new_octet_i = 1'b0;
  endtask

  task automatic end_frame(input string tag);
    repeat (10) @(negedge clk);
    spi_cs_i = 1'b1;
    for (int i = 0; i < 400 && busy_o; i++) @(negedge clk);
    chk(tag, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx"},    {24'd0, spi_tx_o},    32'h5A);
    chk({tag, "_req"},   {31'd0, reg_req_o},   32'd0);
    chk({tag, "_we"},    {31'd0, reg_we_o},    32'd0);
    chk({tag, "_err"},   {31'd0, bus_err_o},   32'd0);
    chk({tag, "_busy"},  {31'd0, busy_o},      32'd0);
    chk({tag, "_addr"},  {25'd0, reg_addr_o},  32'd0);
    chk({tag, "_wdata"}, {24'd0, reg_wdata_o}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cnt;
    for (int i = 0; i < 128; i++) mem[i] = '0;
    rst_i           = 1'b1;
    spi_cs_i        = 1'b1;
    spi_new_octet_i = 1'b0;
    spi_rx_i        = '0;
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    chk_reset_vals("reset");

    // Write burst: (0x10,0xAB) then (0x11,0xCD)
    repeat (3) exp_tx.push_back(8'h5A);
    exp_wr.push_back({7'h10, 8'hAB});
    exp_wr.push_back({7'h11, 8'hCD});
    spi_cs_i = 1'b0;
    send_byte(8'h10, 128);
    chk("wr_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'hAB, 128);
    send_byte(8'hCD, 128);
    end_frame("wr_idle");
    chk("wr_err", {31'd0, bus_err_o}, 32'd0);
    chk("wr_pending", exp_wr.size(), 32'd0);

    // Read burst across the address wrap
    mem[7'h7E] = 8'h11;
    mem[7'h7F] = 8'h22;
    mem[7'h00] = 8'h33;
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h33);
    spi_cs_i = 1'b0;
    send_byte(8'hFE, 128);
    repeat (4) send_byte(8'h00, 128);
    end_frame("rd_idle");
    chk("rd_err", {31'd0, bus_err_o}, 32'd0);

    // Write timeout: no ack at all
    ack_en = 1'b0;
    repeat (2) exp_tx.push_back(8'h5A);
    spi_cs_i = 1'b0;
    send_byte(8'h05, 128);
    send_byte(8'hAA, 128);
    cnt = 0;
    for (int i = 0; i < 30 && !reg_req_o; i++) @(negedge clk);
    while (reg_req_o && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    chk("tmo_len", cnt, 32'd63);
    chk("tmo_err", {31'd0, bus_err_o}, 32'd1);
    end_frame("tmo_idle");
    ack_en = 1'b1;

    // Write overrun with short bytes and slow ack; status byte shows the error
    ack_delay = 50;
    repeat (4) exp_tx.push_back(8'hDA);
    exp_wr.push_back({7'h20, 8'h01});
    exp_wr.push_back({7'h21, 8'h03});
    spi_cs_i = 1'b0;
    send_byte(8'h20, 40);
    send_byte(8'h01, 40);
    send_byte(8'h02, 40);
    send_byte(8'h03, 40);
    end_frame("ovr_idle");
    chk("ovr_err", {31'd0, bus_err_o}, 32'd1);
    chk("ovr_pending", exp_wr.size(), 32'd0);

    // CS abort while a read fetch is pending
    ack_delay = 40;
    exp_tx.push_back(8'hDA);
    spi_cs_i = 1'b0;
    send_byte(8'h85, 128);
    repeat (10) @(negedge clk);
    spi_cs_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_busy", {31'd0, busy_o}, 32'd1);
    chk("abort_req", {31'd0, reg_req_o}, 32'd1);
    for (int i = 0; i < 400 && busy_o; i++) @(negedge clk);
    chk("abort_idle", {31'd0, busy_o}, 32'd0);
    chk("abort_req_low", {31'd0, reg_req_o}, 32'd0);
    chk("abort_err", {31'd0, bus_err_o}, 32'd0);

    // Fresh read frame after the abort
    ack_delay = 2;
    mem[7'h30] = 8'h77;
    exp_tx.push_back(8'h5A);
    exp_tx.push_back(8'hFF);
    exp_tx.push_back(8'h77);
    spi_cs_i = 1'b0;
    send_byte(8'hB0, 128);
    send_byte(8'h00, 128);
    send_byte(8'h00, 128);
    end_frame("rd2_idle");

    // Reset during B_WAIT
    ack_en = 1'b0;
    repeat (2) exp_tx.push_back(8'h5A);
    spi_cs_i = 1'b0;
    send_byte(8'h40, 128);
    send_byte(8'h99, 128);
    for (int i = 0; i < 20 && !reg_req_o; i++) @(negedge clk);
    chk("rst_req_pre", {31'd0, reg_req_o}, 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_wait");
    spi_cs_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i  = 1'b0;
    ack_en = 1'b1;
    repeat (5) @(negedge clk);

    chk("txq_left", exp_tx.size(), 32'd0);
    chk("wrq_left", exp_wr.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command sequencer that sits behind the SPI byte slave on the audio shield FPGA and turns the raw byte stream into register-bus read/write cycles. It synchronises the slave's chip-select and byte-complete strobe into `clk_i`, decodes a command byte (R/W + 7-bit address), and streams auto-incrementing data bytes. It keeps the slave's transmit byte fed from a prefetch buffer so MISO data is always stable before the master samples it.

## Interface
- `DEV_ID`, 7'h5A: ID returned in the status byte during the command phase.
- `TIMEOUT`, 63: `clk_i` cycles a bus cycle may wait for `reg_ack_i` before abort; counter width 8 bits, TIMEOUT ≤ 255.

Ports:
- `clk_i` in 1: system clock; must be ≥ 16 × SCK frequency.
- `rst_i` in 1: reset, synchronous, active-high.
- `spi_cs_i` in 1: raw chip-select from pin, active-low, asynchronous.
- `spi_new_octet_i` in 1: byte strobe from SPI slave, asynchronous; its falling edge marks byte complete.
- `spi_rx_i` in 8: received byte from SPI slave; stable for ≥ ½ SCK after the strobe falls.
- `spi_tx_o` out 8: byte the slave shifts out next.
- `reg_addr_o` out 7: register bus address.
- `reg_wdata_o` out 8: register bus write data.
- `reg_we_o` out 1: 1 = write cycle, 0 = read cycle; valid while `reg_req_o`.
- `reg_req_o` out 1: bus request; held until ack or timeout.
- `reg_rdata_i` in 8: read data; sampled when `reg_ack_i` = 1.
- `reg_ack_i` in 1: single-cycle acknowledge.
- `bus_err_o` out 1: sticky error flag.
- `busy_o` out 1: transaction in progress (CS active or bus cycle pending).

## Operation
- Sync: `spi_new_octet_i` uses a 2-flop synchroniser plus an edge register. The byte event (`byte_ev`) is one cycle on the synchronised falling edge; `spi_rx_i` is captured in that cycle. `spi_cs_i` uses a 3-flop synchroniser (reset value 1), so a byte ending at CS rise is always processed before the CS rise.
- Frame FSM states: IDLE, CMD, WR, RD_TA, RD.
  - IDLE: `spi_tx_o` = {bus_err, DEV_ID}. Synchronised CS low → CMD.
  - CMD: on `byte_ev`: addr ← rx[6:0], bus_err cleared. rx[7] = 0 → WR. rx[7] = 1 → RD_TA, and a read fetch of addr is launched.
  - WR: on `byte_ev`: wdata ← rx and a write cycle is launched at addr. If a bus cycle is still pending, the byte is dropped and bus_err is set. After each completed write, addr increments.
  - RD_TA: turnaround byte; `spi_tx_o` = 8'hFF. On `byte_ev` → RD and the transfer rule below applies.
  - RD (and the RD_TA exit): on `byte_ev`:
    - If the prefetch is valid: `spi_tx_o` ← hold, addr increments, and a fetch of the new addr is launched.
    - If the prefetch is not valid: `spi_tx_o` ← 8'hFF, bus_err is set, and a fetch is launched anyway.
  - Any state: synchronised CS rise → IDLE. A pending bus cycle runs to ack or timeout, then the bus FSM idles. `busy_o` stays high until then.
- Bus FSM states: B_IDLE, B_WAIT.
  - Launch: `reg_req_o` = 1 with addr, `reg_we_o` and wdata held stable; the timeout counter is cleared.
  - `reg_ack_i` → B_IDLE. On a read, hold ← `reg_rdata_i` and prefetch valid ← 1.
  - Counter reaches TIMEOUT → B_IDLE, bus_err ← 1. On a read, hold ← 8'hFF and valid ← 1.
  - `reg_ack_i` in B_IDLE is ignored.
- Address: 7-bit, wraps 7'h7F → 7'h00.
- Prefetch valid is cleared on each transfer to `spi_tx_o` and on CS rise.

## Timing
- Reset values:
  - `spi_tx_o` = {0, DEV_ID}; `reg_req_o`, `reg_we_o`, `bus_err_o`, `busy_o` = 0; `reg_addr_o` = 0; `reg_wdata_o` = 0.
  - FSMs: IDLE / B_IDLE.
  - CS sync = 1, strobe sync = 0.
- `rst_i` mid-frame aborts any bus cycle immediately (`reg_req_o` → 0 the next cycle).
- `byte_ev` fires 3 `clk_i` cycles after the strobe falls. `spi_tx_o` updates 1 cycle after `byte_ev`: 4 cycles total, which is under ½ SCK at the minimum clock ratio of 16.
- Write launch: `reg_req_o` rises the cycle after `byte_ev`.
- Read-data underrun occurs when fetch latency exceeds one byte time (8 SCK) minus 4 cycles.
- `reg_req_o` drops the cycle after ack.

## Test plan
- Write burst: CS low, bytes 0x10, 0xAB, 0xCD, CS high → two bus writes, (0x10, 0xAB) then (0x11, 0xCD); bus_err stays 0; `busy_o` falls after the last ack.
- Read burst: regs 0x7E = 0x11, 0x7F = 0x22, 0x00 = 0x33. Bytes sent 0xFE, 0x00 ×4 → MISO returns {0, 0x5A} status, 0xFF, 0x11, 0x22, 0x33 (address wraps).
- Timeout: slave never acks a write to 0x05 → `reg_req_o` drops after 63 cycles; `bus_err_o` = 1; the next frame's status byte reads 0xDA.
- Write overrun: ack delayed beyond one byte time → the second data byte is dropped and bus_err is set; the next ack increments addr once.
- CS abort mid-read with fetch pending → IDLE after ack; `busy_o` low; a new frame starts clean in CMD.
- `rst_i` asserted during B_WAIT → all outputs return to reset values the next cycle.
